// File: rtl/coin_pkg.sv
// coin_pkg -- shared types and defaults for the coin acceptor.
//   coin_t        : 2-bit coin code as stored in the FIFO and decoded by the emitter
//   emit_state_t  : emit FSM states
//   DEBOUNCE_CYCLES_DEFAULT : default stable-sample count for every debouncer
package coin_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        NICKEL  = 2'b01,
        DIME    = 2'b10,
        QUARTER = 2'b11
    } coin_t;

    typedef enum logic {
        READY = 1'b0,
        HOLD  = 1'b1
    } emit_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/coin_acceptor_debouncer.sv
// debouncer -- two-flop synchronizer followed by a stable-count debouncer.
// The output level follows the synchronized input only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current level.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset (clears synchronizer, counter, level)
//   raw    in  asynchronous input line
//   level  out debounced level
module debouncer
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= 4'd0;
            level   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // Any sample that agrees with the current level restarts the run.
            if (sync_p1 == level) begin
                cnt <= 4'd0;
            end else if (cnt == LAST) begin
                level <= sync_p1;
                cnt   <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor -- debounces three coin sensors and a return button, queues
// accepted coins in a small FIFO, and emits one event pulse at a time to the
// dispenser with a guaranteed idle cycle between events.
// Ports:
//   clk, reset                          clock / asynchronous active-high reset
//   coin_n_raw, coin_d_raw, coin_q_raw  raw coin-slot sensors (asynchronous)
//   return_btn_raw                      raw coin-return button (asynchronous)
//   dis                                 dispenser busy; blocks all emission while high
//   n, d, q, nm                         registered single-cycle event pulses
//   coin_reject                         registered pulse: coin dropped (collision or FIFO full)
//   fifo_count                          number of coins buffered
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              coin_n_raw,
    input  logic                              coin_d_raw,
    input  logic                              coin_q_raw,
    input  logic                              return_btn_raw,
    input  logic                              dis,
    output logic                              n,
    output logic                              d,
    output logic                              q,
    output logic                              nm,
    output logic                              coin_reject,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic lvl_n, lvl_d, lvl_q, lvl_ret;
    logic prev_n, prev_d, prev_q, prev_ret;
    logic ev_n, ev_d, ev_q, ev_ret;
    logic any_ev, multi_ev, single_ev, not_full;
    logic push, pop, clr_ret, reject_d;
    logic n_d, d_d, q_d, nm_d;
    logic ret_pending;
    coin_t push_code, head;
    coin_t mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    emit_state_t state_q, state_d;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_n (
        .clk(clk), .reset(reset), .raw(coin_n_raw), .level(lvl_n));
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
        .clk(clk), .reset(reset), .raw(coin_d_raw), .level(lvl_d));
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_q (
        .clk(clk), .reset(reset), .raw(coin_q_raw), .level(lvl_q));
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ret (
        .clk(clk), .reset(reset), .raw(return_btn_raw), .level(lvl_ret));

    // Rising edges of the debounced levels are the only events.
    assign ev_n   = lvl_n & ~prev_n;
    assign ev_d   = lvl_d & ~prev_d;
    assign ev_q   = lvl_q & ~prev_q;
    assign ev_ret = lvl_ret & ~prev_ret;

    assign any_ev    = ev_n | ev_d | ev_q;
    assign multi_ev  = (ev_n & ev_d) | (ev_n & ev_q) | (ev_d & ev_q);
    assign single_ev = any_ev & ~multi_ev;

    // Fullness uses the registered count only: a same-cycle pop does not
    // free a slot for this cycle's push.
    assign not_full = (fifo_count < DEPTH_C);
    assign push     = single_ev & not_full;
    assign reject_d = multi_ev | (single_ev & ~not_full);
    assign head     = mem[rd_ptr];

    always_comb begin
        push_code = NONE;
        if (ev_n) begin
            push_code = NICKEL;
        end else if (ev_d) begin
            push_code = DIME;
        end else if (ev_q) begin
            push_code = QUARTER;
        end
    end

    // FIFO storage carries data only; it needs no reset because the
    // pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_n      <= 1'b0;
            prev_d      <= 1'b0;
            prev_q      <= 1'b0;
            prev_ret    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            ret_pending <= 1'b0;
        end else begin
            prev_n   <= lvl_n;
            prev_d   <= lvl_d;
            prev_q   <= lvl_q;
            prev_ret <= lvl_ret;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            // A press arriving while a return is already pending is absorbed.
            if (clr_ret) begin
                ret_pending <= 1'b0;
            end else if (ev_ret) begin
                ret_pending <= 1'b1;
            end
        end
    end

    // Emit FSM: state register and registered event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= READY;
            n           <= 1'b0;
            d           <= 1'b0;
            q           <= 1'b0;
            nm          <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state_q     <= state_d;
            n           <= n_d;
            d           <= d_d;
            q           <= q_d;
            nm          <= nm_d;
            coin_reject <= reject_d;
        end
    end

    // Coins outrank a pending return; HOLD forces one idle cycle after
    // every event so the dispenser's vend cycle is never overrun.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        clr_ret = 1'b0;
        n_d     = 1'b0;
        d_d     = 1'b0;
        q_d     = 1'b0;
        nm_d    = 1'b0;
        case (state_q)
            READY: begin
                if (!dis) begin
                    if (fifo_count != '0) begin
                        pop     = 1'b1;
                        state_d = HOLD;
                        case (head)
                            NICKEL:  n_d = 1'b1;
                            DIME:    d_d = 1'b1;
                            QUARTER: q_d = 1'b1;
                            default: ;
                        endcase
                    end else if (ret_pending) begin
                        nm_d    = 1'b1;
                        clr_ret = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a level change on a raw line (range 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4, number of coins buffered awaiting the dispenser (power of two, 2..8).
REQ-003 clk  in  1  system clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 coin_n_raw, coin_d_raw, coin_q_raw  in  1 each  asynchronous coin-slot sensors; high while a nickel, dime or quarter passes.
REQ-006 return_btn_raw  in  1  asynchronous coin-return pushbutton, active-high.
REQ-007 dis  in  1  dispenser vend indication; no coin or return event is emitted while high.
REQ-008 n, d, q, nm  out  1 each  registered single-cycle event pulses to the dispenser: nickel, dime, quarter, no-money/return.
REQ-009 coin_reject  out  1  registered single-cycle pulse: coin dropped, to be physically returned.
REQ-010 fifo_count  out  $clog2(FIFO_DEPTH+1)  coins currently buffered.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer, then a debouncer whose output changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-012 A coin event SHALL be a 0->1 transition of a debounced coin line; falling transitions and held-high levels generate nothing.
REQ-013 Coin events on two or more lines in the same cycle SHALL all be discarded and pulse coin_reject once.
REQ-014 A single coin event SHALL be pushed into the FIFO as its 2-bit code when fifo_count < FIFO_DEPTH; otherwise it is dropped and coin_reject pulses.
REQ-015 Fullness SHALL be evaluated on the registered fifo_count; a pop in the same cycle does not make room for that cycle's push.
REQ-016 A debounced return-button rising edge SHALL set ret_pending; further edges while ret_pending is set are absorbed.
REQ-017 The emit FSM SHALL have states READY and HOLD; reset state READY.
REQ-018 In READY with dis low and the FIFO non-empty: pop the head, assert exactly one of n/d/q for one cycle, go to HOLD.
REQ-019 In READY with dis low, the FIFO empty and ret_pending set: assert nm for one cycle, clear ret_pending, go to HOLD.
REQ-020 In READY with dis high, or with nothing to emit: no output pulse, stay in READY.
REQ-021 HOLD SHALL last exactly one cycle with no pulses, then return to READY, guaranteeing at least one idle cycle between events so the dispenser's vend cycle is never overrun.
REQ-022 Coins SHALL take priority over a pending return; nm is emitted only after the FIFO drains.
REQ-023 n, d, q and nm SHALL be mutually exclusive in every cycle.
REQ-024 Minimum latency, from the first clk edge sampling a raw coin high to the corresponding pulse, SHALL be DEBOUNCE_CYCLES+3 cycles with an empty FIFO, READY state and dis low.
REQ-025 A push and a pop in the same cycle SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 Reset SHALL clear synchronizers, debouncer counters and levels (0), FIFO pointers, fifo_count (0), ret_pending (0) and the FSM (READY).
REQ-027 n, d, q, nm and coin_reject SHALL be 0 during and immediately after reset.
REQ-028 Reset mid-operation SHALL discard all buffered coins and pending returns; no pulse follows reset deassertion until a new debounced event occurs.

Structure
REQ-029 Package coin_pkg SHALL hold the coin code typedef (NONE=00, NICKEL=01, DIME=10, QUARTER=11), the emit FSM state typedef and the DEBOUNCE_CYCLES default.
REQ-030 The synchronizer plus debouncer SHALL be one sub-module, debouncer, instantiated four times; the FIFO and FSM stay inline.

Verification
REQ-031 Nickel raw high for 10 cycles, FIFO empty, dis low -> n pulses for one cycle at DEBOUNCE_CYCLES+3 = 7 cycles; fifo_count returns to 0.
REQ-032 Dime raw with 2-cycle glitches, then a 3-cycle stable high (DEBOUNCE_CYCLES=4) -> no pulse, no coin_reject.
REQ-033 Five quarters queued while dis held high -> fifo_count reaches 4, one coin_reject; after dis low, q pulses 4 times, each separated by at least one idle cycle.
REQ-034 Nickel and dime debounced edges in the same cycle -> single coin_reject pulse, no n or d, fifo_count 0.
REQ-035 Return pressed with 2 coins buffered -> coins emitted first, then nm once; a second press while pending yields no extra nm.
REQ-036 Reset asserted with 3 coins buffered -> fifo_count 0 and all outputs 0; no pulse follows deassertion.
